// File: rtl/prog_loader.sv
// Program loader: streams a length-prefixed byte image into CPU RAM, holds the
// CPU in reset meanwhile, then releases it and pulses cpu_run. Optional
// trailing checksum byte is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter logic [7:0] BASE_ADDR = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_req,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       rx_ready,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       mem_wren,
   output logic       cpu_hold,
   output logic       cpu_run,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_REL,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t     r_state;
   logic       r_rx_ready;
   logic [7:0] r_mem_addr;
   logic [7:0] r_mem_data;
   logic       r_mem_wren;
   logic       r_cpu_hold;
   logic       r_cpu_run;
   logic       r_done;
   logic       r_err;
   logic [8:0] r_count;
   logic [7:0] r_ptr;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] r_acc;
`endif
   logic       w_xfer;

   assign w_xfer = rx_valid && r_rx_ready;

   // Outputs are registered: each transition loads the values of the state it enters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_rx_ready <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_mem_wren <= 1'b0;
         r_cpu_hold <= 1'b0;
         r_cpu_run  <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_count    <= '0;
         r_ptr      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         r_acc      <= '0;
`endif
      end else begin
         r_mem_wren <= 1'b0;
         r_cpu_run  <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (load_req) begin
                  r_state    <= S_LEN;
                  r_rx_ready <= 1'b1;
                  r_cpu_hold <= 1'b1;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  // A length byte of zero encodes a full 256-byte image.
                  r_count <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                  r_ptr   <= BASE_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
                  r_acc   <= '0;
`endif
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_mem_addr <= r_ptr;
                  r_mem_data <= rx_data;
                  r_mem_wren <= 1'b1;
                  r_ptr      <= r_ptr + 8'd1;
                  r_count    <= r_count - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                  r_acc      <= r_acc + rx_data;
                  if (r_count == 9'd1) begin
                     r_state <= S_CSUM;
                  end
`else
                  if (r_count == 9'd1) begin
                     r_state    <= S_REL;
                     r_rx_ready <= 1'b0;
                     r_cpu_hold <= 1'b0;
                  end
`endif
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_xfer) begin
                  r_rx_ready <= 1'b0;
                  if (rx_data == r_acc) begin
                     r_state    <= S_REL;
                     r_cpu_hold <= 1'b0;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
`endif
            S_REL: begin
               r_state   <= S_RUN;
               r_cpu_run <= 1'b1;
            end
            S_RUN: begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
            default: begin
               r_state    <= S_IDLE;
               r_rx_ready <= 1'b0;
               r_cpu_hold <= 1'b0;
            end
         endcase
      end
   end

   assign rx_ready = r_rx_ready;
   assign mem_addr = r_mem_addr;
   assign mem_data = r_mem_data;
   assign mem_wren = r_mem_wren;
   assign cpu_hold = r_cpu_hold;
   assign cpu_run  = r_cpu_run;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (BASE_ADDR 00 and FE) share one
// stimulus stream; expected writes and run pulses are queued and checked by monitors.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_req = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = '0;

   logic       rdy0, we0, h0, run0, dn0, er0;
   logic       rdy1, we1, h1, run1, dn1, er1;
   logic [7:0] a0, d0, a1, d1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int         c;
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        q0[$];
   wr_t        q1[$];
   int         rq0[$];
   int         rq1[$];
   logic [7:0] pay[$];

   prog_loader #(.BASE_ADDR(8'h00)) u0 (
      .clk(clk), .rst(rst), .load_req(load_req), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rdy0), .mem_addr(a0), .mem_data(d0), .mem_wren(we0),
      .cpu_hold(h0), .cpu_run(run0), .done(dn0), .err(er0)
   );

   prog_loader #(.BASE_ADDR(8'hFE)) u1 (
      .clk(clk), .rst(rst), .load_req(load_req), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rdy1), .mem_addr(a1), .mem_data(d1), .mem_wren(we1),
      .cpu_hold(h1), .cpu_run(run1), .done(dn1), .err(er1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm, input string detail);
      checks++;
      errors++;
      $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
   endtask

   // Write monitors
   always @(negedge clk) begin
      wr_t e;
      if (we0) begin
         if (q0.size() == 0) fail("u0 write", $sformatf("got %h:%h, required no write", a0, d0));
         else begin
            e = q0.pop_front();
            chk("u0 write cycle", cyc, e.c);
            chk("u0 write addr", a0, e.a);
            chk("u0 write data", d0, e.d);
         end
      end
      if (we1) begin
         if (q1.size() == 0) fail("u1 write", $sformatf("got %h:%h, required no write", a1, d1));
         else begin
            e = q1.pop_front();
            chk("u1 write cycle", cyc, e.c);
            chk("u1 write addr", a1, e.a);
            chk("u1 write data", d1, e.d);
         end
      end
   end

   // Run-pulse monitors
   always @(negedge clk) begin
      if (run0) begin
         if (rq0.size() == 0) fail("u0 cpu_run", "got pulse, required none");
         else chk("u0 cpu_run cycle", cyc, rq0.pop_front());
      end
      if (run1) begin
         if (rq1.size() == 0) fail("u1 cpu_run", "got pulse, required none");
         else chk("u1 cpu_run cycle", cyc, rq1.pop_front());
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output int k);
      rx_valid = 1'b0;
      step(gap);
      rx_valid = 1'b1;
      rx_data  = b;
      k = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rdy0 && rdy1) begin
            @(posedge clk);
            #1;
            k = cyc;
            break;
         end
      end
      rx_valid = 1'b0;
      if (k < 0) fail("rx_ready timeout", $sformatf("byte %h not accepted in 20 cycles", b));
   endtask

   task automatic pulse_req();
      load_req = 1'b1;
      step(1);
      load_req = 1'b0;
      chk("LEN cpu_hold", h0, 1);
      chk("LEN rx_ready", rdy0, 1);
      chk("LEN done", dn0, 0);
      chk("LEN err", er0, 0);
   endtask

   task automatic load_image(input int gap, input bit bad_csum);
      int         k;
      logic [7:0] sum;
      sum = '0;
      pulse_req();
      send_byte(8'(pay.size()), 0, k);
      chk("DATA cpu_hold", h0, 1);
      foreach (pay[i]) begin
         send_byte(pay[i], (i == 0) ? 0 : gap, k);
         q0.push_back('{k, 8'h00 + 8'(i), pay[i]});
         q1.push_back('{k, 8'hFE + 8'(i), pay[i]});
         sum = sum + pay[i];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? sum + 8'd1 : sum, 0, k);
`endif
      if (!bad_csum) begin
         rq0.push_back(k + 1);
         rq1.push_back(k + 1);
      end
   endtask

   task automatic expect_done();
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (dn0 && dn1) break;
      end
      chk("u0 done", dn0, 1);
      chk("u1 done", dn1, 1);
      chk("done cpu_hold", h0, 0);
      chk("done err", er0, 0);
      chk("done rx_ready", rdy0, 0);
      step(1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " rx_ready"}, rdy0, 0);
      chk({tag, " mem_wren"}, we0, 0);
      chk({tag, " u0 mem_addr"}, a0, 0);
      chk({tag, " u0 mem_data"}, d0, 0);
      chk({tag, " u1 mem_addr"}, a1, 0);
      chk({tag, " u1 mem_data"}, d1, 0);
      chk({tag, " cpu_hold"}, h0, 0);
      chk({tag, " cpu_run"}, run0, 0);
      chk({tag, " done"}, dn0, 0);
      chk({tag, " err"}, er0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   initial begin
      int k;
      #1;
      chk_reset_outputs("por");
      step(2);
      rst = 1'b1;
      step(1);

      // Basic back-to-back load
      pay = '{8'hAA, 8'hBB, 8'hCC};
      load_image(0, 1'b0);
      expect_done();

      // Wrap test (FE base wraps on u1)
      pay = '{8'h11, 8'h22, 8'h33};
      load_image(0, 1'b0);
      expect_done();

      // Gaps of 3 idle cycles between payload bytes
      pay = '{8'h55, 8'h66};
      load_image(3, 1'b0);
      expect_done();

      // Full 256-byte image, length byte 00
      pay.delete();
      for (int i = 0; i < 256; i++) pay.push_back(8'(i));
      load_image(0, 1'b0);
      expect_done();

      // Reset during DATA after first of four bytes
      pulse_req();
      send_byte(8'd4, 0, k);
      send_byte(8'h01, 0, k);
      q0.push_back('{k, 8'h00, 8'h01});
      q1.push_back('{k, 8'hFE, 8'h01});
      @(negedge clk);
      #1;
      rst = 1'b0;
      rx_valid = 1'b1;
      rx_data = 8'h02;
      #1;
      chk_reset_outputs("midload");
      step(3);
      chk("reset rx_ready", rdy0, 0);
      rx_valid = 1'b0;
      rst = 1'b1;
      step(1);
      chk("post-reset cpu_hold", h0, 0);
      pay = '{8'hAA, 8'hBB, 8'hCC};
      load_image(0, 1'b0);
      expect_done();

`ifdef PROG_LOADER_CHECKSUM_EN
      // Bad checksum: 02,10,20,31
      pay = '{8'h10, 8'h20};
      load_image(0, 1'b1);
      step(3);
      chk("csum err", er0, 1);
      chk("csum err cpu_hold", h0, 1);
      chk("csum err done", dn0, 0);
      chk("csum err rx_ready", rdy0, 0);
      load_image(0, 1'b0);
      expect_done();
`else
      chk("err stays low", er0 | er1, 0);
`endif

      step(5);
      chk("u0 writes outstanding", q0.size(), 0);
      chk("u1 writes outstanding", q1.size(), 0);
      chk("u0 runs outstanding", rq0.size(), 0);
      chk("u1 runs outstanding", rq1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
